// File: rtl/vector_ctrl_pkg.sv
// Shared opcode constants, ALU/control/state types for the vector issue controller.
package vector_ctrl_pkg;

  localparam logic [4:0] OP_MOVI   = 5'b10111;
  localparam logic [4:0] OP_ADD    = 5'b11000;
  localparam logic [4:0] OP_MOVR   = 5'b11011;
  localparam logic [4:0] OP_MUL    = 5'b11111;
  localparam logic [4:0] OP_SUB    = 5'b11110;
  localparam logic [4:0] OP_XOR    = 5'b01100;
  localparam logic [4:0] OP_VADD   = 5'b10001;
  localparam logic [4:0] OP_VMOVI  = 5'b10010;
  localparam logic [4:0] OP_VXOR   = 5'b10011;
  localparam logic [4:0] OP_VLOAD  = 5'b10100;
  localparam logic [4:0] OP_VSTORE = 5'b10101;
  localparam logic [4:0] OP_BRANCH = 5'b00001;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_XOR = 2'b11
  } alu_ctrl_t;

  typedef struct packed {
    alu_ctrl_t alu_control;
    logic      reg_write;
    logic      vreg_write;
    logic      mem_write;
    logic      mem_to_reg;
    logic      branch;
    logic      alu_src;
  } ctrl_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SCALAR = 2'b01,
    S_VSEQ   = 2'b10
  } state_t;

endpackage

// File: rtl/vector_ctrl_decode.sv
// Combinational opcode decoder: datapath controls plus vector/illegal classification.
module vector_ctrl_decode
  import vector_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output ctrl_t      ctrl,
  output logic       is_vector,
  output logic       illegal
);

  always_comb begin
    ctrl      = '0;
    is_vector = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_MOVI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_ADD, OP_MOVR: ctrl.reg_write = 1'b1;
      OP_MUL: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = ALU_MUL;
      end
      OP_SUB: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = ALU_SUB;
      end
      OP_XOR: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = ALU_XOR;
      end
      OP_VADD: begin
        ctrl.vreg_write = 1'b1;
        is_vector       = 1'b1;
      end
      OP_VMOVI: begin
        ctrl.vreg_write = 1'b1;
        ctrl.alu_src    = 1'b1;
        is_vector       = 1'b1;
      end
      OP_VXOR: begin
        ctrl.vreg_write  = 1'b1;
        ctrl.alu_control = ALU_XOR;
        is_vector        = 1'b1;
      end
      OP_VLOAD: begin
        ctrl.vreg_write = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        is_vector       = 1'b1;
      end
      OP_VSTORE: begin
        ctrl.mem_write = 1'b1;
        is_vector      = 1'b1;
      end
      OP_BRANCH: ctrl.branch = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/vector_issue_ctrl.sv
// Vector issue controller: accepts one instruction, issues it as one or more lane beats.
// Optional build macro ILLEGAL_TRAP_EN makes an illegal beat a sticky trap until reset.
module vector_issue_ctrl
  import vector_ctrl_pkg::*;
#(
  parameter int LANES          = 4,
  parameter int LANES_PER_BEAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [4:0]       opcode,
  input  logic             rd_type,
  input  logic             rs1_type,
  input  logic             rs2_type,
  output logic             ctrl_valid,
  input  logic             ex_ready,
  output logic [1:0]       alu_control,
  output logic             reg_write,
  output logic             vreg_write,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             branch,
  output logic             alu_src,
  output logic [LANES-1:0] lane_sel,
  output logic             beat_last,
  output logic             illegal
);

  localparam int BEATS = LANES / LANES_PER_BEAT;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  state_t           state_p1, state_n;
  ctrl_t            ctrl_p1, ctrl_n;
  logic [LANES-1:0] lane_p1, lane_n;
  logic [BW-1:0]    beat_p1, beat_n, beat_inc;
  logic             last_p1, last_n;
  logic             ill_p1, ill_n;
  logic             vld_p1, vld_n;
  logic             started_p1;

  ctrl_t dec_ctrl;
  logic  dec_vec, dec_ill;
  logic  accept, beat_done, trap_block;

  // Operand classes do not influence control decode.
  logic unused_types;
  assign unused_types = ^{rd_type, rs1_type, rs2_type};

  function automatic logic [LANES-1:0] group_mask(input logic [BW-1:0] beat);
    logic [LANES-1:0] base;
    base = LANES'((64'd1 << LANES_PER_BEAT) - 64'd1);
    return base << (LANES_PER_BEAT * int'(beat));
  endfunction

  vector_ctrl_decode u_decode (
    .opcode    (opcode),
    .ctrl      (dec_ctrl),
    .is_vector (dec_vec),
    .illegal   (dec_ill)
  );

`ifdef ILLEGAL_TRAP_EN
  assign trap_block = ill_p1;
`else
  assign trap_block = 1'b0;
`endif

  // started_p1 keeps instr_ready low until the first edge after reset release
  assign instr_ready = started_p1 && !trap_block &&
                       ((state_p1 == S_IDLE) || (last_p1 && ex_ready));
  assign accept      = instr_valid && instr_ready;
  assign beat_done   = vld_p1 && ex_ready;
  assign beat_inc    = beat_p1 + 1'b1;

  always_comb begin
    state_n = state_p1;
    vld_n   = vld_p1;
    ctrl_n  = ctrl_p1;
    lane_n  = lane_p1;
    beat_n  = beat_p1;
    last_n  = last_p1;
    ill_n   = ill_p1;
    if (beat_done) begin
      if (last_p1) begin
        state_n = S_IDLE;
        vld_n   = 1'b0;
        ctrl_n  = '0;
        lane_n  = '0;
        last_n  = 1'b0;
        beat_n  = '0;
`ifdef ILLEGAL_TRAP_EN
        ill_n   = ill_p1;
`else
        ill_n   = 1'b0;
`endif
      end else begin
        beat_n = beat_inc;
        lane_n = group_mask(beat_inc);
        last_n = (beat_inc == LAST_BEAT);
      end
    end
    // an accept on the last-beat handshake overrides the return to idle
    if (accept) begin
      vld_n  = 1'b1;
      ctrl_n = dec_ctrl;
      ill_n  = dec_ill;
      beat_n = '0;
      if (dec_vec) begin
        state_n = S_VSEQ;
        lane_n  = group_mask('0);
        last_n  = (BEATS == 1);
      end else begin
        state_n = S_SCALAR;
        lane_n  = '1;
        last_n  = 1'b1;
      end
    end
  end

  // issue stage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1   <= S_IDLE;
      vld_p1     <= 1'b0;
      ctrl_p1    <= '0;
      lane_p1    <= '0;
      beat_p1    <= '0;
      last_p1    <= 1'b0;
      ill_p1     <= 1'b0;
      started_p1 <= 1'b0;
    end else begin
      state_p1   <= state_n;
      vld_p1     <= vld_n;
      ctrl_p1    <= ctrl_n;
      lane_p1    <= lane_n;
      beat_p1    <= beat_n;
      last_p1    <= last_n;
      ill_p1     <= ill_n;
      started_p1 <= 1'b1;
    end
  end

  assign ctrl_valid  = vld_p1;
  assign alu_control = ctrl_p1.alu_control;
  assign reg_write   = ctrl_p1.reg_write;
  assign vreg_write  = ctrl_p1.vreg_write;
  assign mem_write   = ctrl_p1.mem_write;
  assign mem_to_reg  = ctrl_p1.mem_to_reg;
  assign branch      = ctrl_p1.branch;
  assign alu_src     = ctrl_p1.alu_src;
  assign lane_sel    = lane_p1;
  assign beat_last   = last_p1;
  assign illegal     = ill_p1;

endmodule

// File: tb/tb_vector_issue_ctrl.sv
// Scoreboard bench for vector_issue_ctrl: accepted instructions expand into expected beats.
module tb_vector_issue_ctrl;

  localparam int LANES = 4;
  localparam int LPB   = 1;
  localparam int BEATS = LANES / LPB;

  logic             clk;
  logic             rst_n;
  logic             instr_valid;
  logic             instr_ready;
  logic [4:0]       opcode;
  logic             rd_type, rs1_type, rs2_type;
  logic             ctrl_valid;
  logic             ex_ready;
  logic [1:0]       alu_control;
  logic             reg_write, vreg_write, mem_write, mem_to_reg, branch, alu_src;
  logic [LANES-1:0] lane_sel;
  logic             beat_last;
  logic             illegal;

  vector_issue_ctrl #(.LANES(LANES), .LANES_PER_BEAT(LPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .rd_type     (rd_type),
    .rs1_type    (rs1_type),
    .rs2_type    (rs2_type),
    .ctrl_valid  (ctrl_valid),
    .ex_ready    (ex_ready),
    .alu_control (alu_control),
    .reg_write   (reg_write),
    .vreg_write  (vreg_write),
    .mem_write   (mem_write),
    .mem_to_reg  (mem_to_reg),
    .branch      (branch),
    .alu_src     (alu_src),
    .lane_sel    (lane_sel),
    .beat_last   (beat_last),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       alu;
    logic             rw, vw, mw, m2r, br, src;
    logic [LANES-1:0] lane;
    logic             last;
    logic             ill;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    acc_cnt = 0;
  int    timeouts = 0;
  int    timeouts_seen = 0;
  bit    prev_rst = 1'b0;
  bit    started_m = 1'b0;
  bit    trapped_m = 1'b0;
  bit    ready_rand = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: what each opcode must look like on the output, beat by beat.
  function automatic bit push_instr(input logic [4:0] op);
    beat_t b;
    bit    vec;
    b   = '0;
    vec = 1'b0;
    case (op)
      5'b10111: begin b.rw = 1; b.src = 1; end
      5'b11000: b.rw = 1;
      5'b11011: b.rw = 1;
      5'b11111: begin b.rw = 1; b.alu = 2'd2; end
      5'b11110: begin b.rw = 1; b.alu = 2'd1; end
      5'b01100: begin b.rw = 1; b.alu = 2'd3; end
      5'b10001: begin b.vw = 1; vec = 1; end
      5'b10010: begin b.vw = 1; b.src = 1; vec = 1; end
      5'b10011: begin b.vw = 1; b.alu = 2'd3; vec = 1; end
      5'b10100: begin b.vw = 1; b.m2r = 1; vec = 1; end
      5'b10101: begin b.mw = 1; vec = 1; end
      5'b00001: b.br = 1;
      default:  b.ill = 1;
    endcase
    if (vec) begin
      for (int k = 0; k < BEATS; k++) begin
        b.lane = LANES'(((1 << LPB) - 1) << (k * LPB));
        b.last = (k == BEATS - 1);
        exp_q.push_back(b);
      end
    end else begin
      b.lane = '1;
      b.last = 1'b1;
      exp_q.push_back(b);
    end
    return b.ill;
  endfunction

  // Monitor: compares everything the DUT presents against the scoreboard.
  always @(negedge clk) begin
    beat_t act;
    bit    exp_ready;
    act = {alu_control, reg_write, vreg_write, mem_write, mem_to_reg, branch, alu_src,
           lane_sel, beat_last, illegal};
    if (timeouts != timeouts_seen) begin
      chk("send_timeout", 32'(timeouts), 32'(timeouts_seen));
      timeouts_seen = timeouts;
    end
    if (!rst_n) begin
      exp_q.delete();
      trapped_m = 1'b0;
      started_m = 1'b0;
      chk("reset_outputs", 32'({act, ctrl_valid, instr_ready}), 32'd0);
    end else begin
      started_m = prev_rst;
      exp_ready = started_m && !trapped_m &&
                  ((exp_q.size() == 0) || ((exp_q.size() == 1) && ex_ready));
      chk("instr_ready", 32'(instr_ready), 32'(exp_ready));
      chk("ctrl_valid", 32'(ctrl_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0 && ctrl_valid) begin
        if (ex_ready) begin
          chk("beat", 32'(act), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end else begin
          chk("stall_hold", 32'(act), 32'(exp_q[0]));
        end
      end else if (exp_q.size() == 0) begin
        chk("idle_illegal", 32'(illegal), 32'(trapped_m));
      end
      if (instr_valid && instr_ready) begin
        acc_cnt++;
`ifdef ILLEGAL_TRAP_EN
        if (push_instr(opcode)) trapped_m = 1'b1;
`else
        void'(push_instr(opcode));
`endif
      end
    end
    prev_rst = rst_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (ready_rand) ex_ready = ($urandom_range(0, 99) < 70);
  endtask

  task automatic send(input logic [4:0] op);
    int start;
    int n;
    start       = acc_cnt;
    n           = 0;
    instr_valid = 1'b1;
    opcode      = op;
    rd_type     = 1'($urandom_range(0, 1));
    rs1_type    = 1'($urandom_range(0, 1));
    rs2_type    = 1'($urandom_range(0, 1));
    while (acc_cnt == start && n < 100) begin
      tick();
      n++;
    end
    if (acc_cnt == start) timeouts++;
    instr_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [4:0] ops [12];
  logic [4:0] op;

  initial begin
    ops = '{5'b10111, 5'b11000, 5'b11011, 5'b11111, 5'b11110, 5'b01100,
            5'b10001, 5'b10010, 5'b10011, 5'b10100, 5'b10101, 5'b00001};
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    opcode      = '0;
    rd_type     = 1'b0;
    rs1_type    = 1'b0;
    rs2_type    = 1'b0;
    ex_ready    = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    send(5'b11000);
    repeat (2) tick();

    send(5'b10001);
    repeat (5) tick();

    send(5'b10011);
    tick();
    ex_ready = 1'b0;
    repeat (3) tick();
    ex_ready = 1'b1;
    repeat (4) tick();

    send(5'b10010);
    send(5'b11111);
    repeat (3) tick();

    send(5'b10001);
    repeat (2) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    send(5'b10001);
    repeat (5) tick();

    send(5'b00000);
    repeat (3) tick();
`ifdef ILLEGAL_TRAP_EN
    instr_valid = 1'b1;
    opcode      = 5'b11000;
    repeat (5) tick();
    instr_valid = 1'b0;
    do_reset();
`else
    send(5'b11000);
    repeat (3) tick();
`endif

    ready_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 8) op = ops[$urandom_range(0, 11)];
      else                          op = 5'($urandom_range(0, 31));
      send(op);
      if (trapped_m) begin
        repeat (4) tick();
        do_reset();
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    ready_rand = 1'b0;
    ex_ready   = 1'b1;
    repeat (10) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
